dac_multi_channel_output: RTL and testbench

Parametrised successor to the two-channel sample-to-DAC path. It latches CHANNELS signed samples on a start strobe, then for each channel adds a DC offset, scales, and either saturates or truncates to the DAC width. It prepends a per-channel command byte and serialises each word as its own SPI frame through an integrated transmitter. It sits between the synthesis engine's per-sample output strobe and the external multi-channel SPI DAC.

---
 rtl/dac_output_pkg.sv | 22 ++
 rtl/dac_spi_tx.sv | 80 ++++++++
 rtl/dac_multi_channel_output.sv | 129 ++++++++++++
 tb/tb_dac_multi_channel_output.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_output_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_output_pkg : states, frame width and default DAC command values  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dac_output_pkg;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LOAD   = 3'd1;
  localparam logic [2:0] c_ST_FORMAT = 3'd2;
  localparam logic [2:0] c_ST_SEND   = 3'd3;
  localparam logic [2:0] c_ST_GAP    = 3'd4;

  localparam logic [7:0]  c_CMD_BASE_DEFAULT      = 8'h31;
  localparam logic [31:0] c_SAMPLE_OFFSET_DEFAULT = 32'h0002_0500;

  function automatic int frame_bits(input int cmd_bits, input int dac_bits);
    return cmd_bits + dac_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_spi_tx : single-frame SPI mode-0 transmitter, MSB first          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dac_spi_tx #(
  parameter int FRAME_BITS = 24,
  parameter int CLK_DIV    = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Load,
  input  logic [FRAME_BITS-1:0] i_Word,
  output logic                  o_Done,
  output logic                  o_SPI_CS,
  output logic                  o_SPI_Clock,
  output logic                  o_SPI_Data
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] c_LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                  active_q;
  logic                  cs_q;
  logic                  sclk_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [DIV_W-1:0]      div_cnt_q;
  logic                  w_phase_end;
  logic                  w_last;

  assign w_phase_end = active_q && (div_cnt_q == c_DIV_LAST);
  assign w_last      = w_phase_end && sclk_q && (bit_cnt_q == c_LAST_BIT);

  // The shifter is cleared at frame end so MOSI reads 0 while CS is high.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      active_q  <= 1'b0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else if (i_Load) begin
      active_q  <= 1'b1;
      cs_q      <= 1'b0;
      sclk_q    <= 1'b0;
      shreg_q   <= i_Word;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else if (active_q) begin
      if (w_phase_end) begin
        div_cnt_q <= '0;
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else if (w_last) begin
          active_q <= 1'b0;
          cs_q     <= 1'b1;
          sclk_q   <= 1'b0;
          shreg_q  <= '0;
        end else begin
          sclk_q    <= 1'b0;
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          shreg_q   <= {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign o_Done      = w_last;
  assign o_SPI_CS    = cs_q;
  assign o_SPI_Clock = sclk_q;
  assign o_SPI_Data  = shreg_q[FRAME_BITS-1];

endmodule
`default_nettype wire

// File: rtl/dac_multi_channel_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dac_multi_channel_output : offset/scale/clamp samples, send per-chan |
// | SPI frames to a multi-channel DAC.            Rev 1.0                |
// +----------------------------------------------------------------------+
module dac_multi_channel_output
  import dac_output_pkg::*;
#(
  parameter int                      CHANNELS      = 2,
  parameter int                      SAMPLE_WIDTH  = 32,
  parameter int                      DAC_BITS      = 16,
  parameter int                      COMMAND_BITS  = 8,
  parameter logic [COMMAND_BITS-1:0] CMD_BASE      = c_CMD_BASE_DEFAULT,
  parameter logic [SAMPLE_WIDTH-1:0] SAMPLE_OFFSET = c_SAMPLE_OFFSET_DEFAULT,
  parameter int                      SHIFT         = 2,
  parameter int                      SATURATE      = 1,
  parameter int                      CLK_DIV       = 2,
  parameter int                      CS_GAP        = 2
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Start,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] i_Samples,
  output logic                             o_SPI_CS,
  output logic                             o_SPI_Clock,
  output logic                             o_SPI_Data,
  output logic                             o_Busy,
  output logic                             o_Clip,
  output logic                             o_Overrun
);

  localparam int FRAME_BITS = frame_bits(COMMAND_BITS, DAC_BITS);
  localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int GAP_W      = $clog2(CS_GAP + 1);
  localparam logic [IDX_W-1:0]      c_LAST_IDX    = IDX_W'(CHANNELS - 1);
  localparam logic [GAP_W-1:0]      c_GAP_LAST    = GAP_W'(CS_GAP - 1);
  localparam logic [SAMPLE_WIDTH:0] c_OFFSET_EXT  = {SAMPLE_OFFSET[SAMPLE_WIDTH-1], SAMPLE_OFFSET};
  localparam logic [SAMPLE_WIDTH:0] c_DAC_MAX_EXT = {{(SAMPLE_WIDTH+1-DAC_BITS){1'b0}}, {DAC_BITS{1'b1}}};

  logic [2:0]                      state_q, state_d;
  logic [CHANNELS*SAMPLE_WIDTH-1:0] samples_q;
  logic [IDX_W-1:0]                idx_q;
  logic [GAP_W-1:0]                gap_cnt_q;
  logic signed [SAMPLE_WIDTH:0]    sum_q;
  logic                            overrun_q;

  logic [SAMPLE_WIDTH-1:0]         w_sample;
  logic signed [SAMPLE_WIDTH:0]    w_sample_ext;
  logic signed [SAMPLE_WIDTH:0]    w_scaled;
  logic                            w_neg, w_over;
  logic [DAC_BITS-1:0]             w_value;
  logic [COMMAND_BITS-1:0]         w_cmd;
  logic                            w_gap_done;
  logic                            w_tx_done;

  assign w_sample     = samples_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  assign w_sample_ext = {w_sample[SAMPLE_WIDTH-1], w_sample};
  assign w_scaled     = sum_q >>> SHIFT;
  assign w_neg        = w_scaled[SAMPLE_WIDTH];
  assign w_over       = !w_neg && ($unsigned(w_scaled) > c_DAC_MAX_EXT);

  // Without saturation the low DAC_BITS of the shifted sum wrap, as the legacy path did.
  assign w_value = (SATURATE != 0) ? (w_neg  ? '0 :
                                      w_over ? '1 : w_scaled[DAC_BITS-1:0])
                                   : w_scaled[DAC_BITS-1:0];
  assign w_cmd      = CMD_BASE + COMMAND_BITS'(idx_q);
  assign w_gap_done = (gap_cnt_q == c_GAP_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (i_Start) state_d = c_ST_LOAD;
      c_ST_LOAD:   state_d = c_ST_FORMAT;
      c_ST_FORMAT: state_d = c_ST_SEND;
      c_ST_SEND:   if (w_tx_done) state_d = c_ST_GAP;
      c_ST_GAP:    if (w_gap_done) state_d = (idx_q == c_LAST_IDX) ? c_ST_IDLE : c_ST_LOAD;
      default:     state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= c_ST_IDLE;
      samples_q <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= i_Start && (state_q != c_ST_IDLE);
      if ((state_q == c_ST_IDLE) && i_Start) begin
        samples_q <= i_Samples;
        idx_q     <= '0;
      end
      if (state_q == c_ST_LOAD) begin
        sum_q <= w_sample_ext + c_OFFSET_EXT;
      end
      if (state_q == c_ST_GAP) begin
        if (w_gap_done) begin
          gap_cnt_q <= '0;
          if (idx_q != c_LAST_IDX) idx_q <= idx_q + IDX_W'(1);
        end else begin
          gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end
      end
    end
  end

  dac_spi_tx #(
    .FRAME_BITS (FRAME_BITS),
    .CLK_DIV    (CLK_DIV)
  ) u_spi_tx (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Load      (state_q == c_ST_FORMAT),
    .i_Word      ({w_cmd, w_value}),
    .o_Done      (w_tx_done),
    .o_SPI_CS    (o_SPI_CS),
    .o_SPI_Clock (o_SPI_Clock),
    .o_SPI_Data  (o_SPI_Data)
  );

  assign o_Busy    = (state_q != c_ST_IDLE);
  assign o_Clip    = (state_q == c_ST_FORMAT) && (SATURATE != 0) && (w_neg || w_over);
  assign o_Overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_multi_channel_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dac_multi_channel_output : vector table + SPI frame scoreboard    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dac_multi_channel_output;

  typedef struct {
    int          inst;
    logic [23:0] frame;
    int          cs_len;
  } exp_t;

  typedef struct {
    int          inst;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [23:0] f0;
    logic [23:0] f1;
    int          clips;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start [3];
  logic [63:0]  samp01;
  logic [127:0] samp2;
  logic         cs_w [3], sclk_w [3], data_w [3], busy_w [3], clip_w [3], ovr_w [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   viol     = 0;
  bit   mon_en   = 1'b0;
  exp_t exp_q[$];

  logic [23:0] rx [3];
  int          nbits [3];
  int          cslen [3];
  bit          abort [3];
  logic        cs_prev [3], sclk_prev [3], data_prev [3];

  always #5 clk = ~clk;

  dac_multi_channel_output u_dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[0]), .i_Samples(samp01),
    .o_SPI_CS(cs_w[0]), .o_SPI_Clock(sclk_w[0]), .o_SPI_Data(data_w[0]),
    .o_Busy(busy_w[0]), .o_Clip(clip_w[0]), .o_Overrun(ovr_w[0]));

  dac_multi_channel_output #(.SATURATE(0)) u_dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[1]), .i_Samples(samp01),
    .o_SPI_CS(cs_w[1]), .o_SPI_Clock(sclk_w[1]), .o_SPI_Data(data_w[1]),
    .o_Busy(busy_w[1]), .o_Clip(clip_w[1]), .o_Overrun(ovr_w[1]));

  dac_multi_channel_output #(.CHANNELS(4), .CLK_DIV(1), .CS_GAP(1)) u_dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[2]), .i_Samples(samp2),
    .o_SPI_CS(cs_w[2]), .o_SPI_Clock(sclk_w[2]), .o_SPI_Data(data_w[2]),
    .o_Busy(busy_w[2]), .o_Clip(clip_w[2]), .o_Overrun(ovr_w[2]));

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic void push_exp(input int m, input logic [23:0] f, input int len);
    exp_t e;
    e.inst = m; e.frame = f; e.cs_len = len;
    exp_q.push_back(e);
  endfunction

  // SPI receiver: bits captured on SCLK rising, frame closed on CS rising.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int m = 0; m < 3; m++) begin
        if (!cs_w[m]) begin
          cslen[m]++;
          if (sclk_w[m] && !sclk_prev[m]) begin
            rx[m] = {rx[m][22:0], data_w[m]};
            nbits[m]++;
          end
          if (!cs_prev[m] && (data_w[m] !== data_prev[m]) && !(sclk_prev[m] && !sclk_w[m]))
            viol++;
        end else begin
          if ((sclk_w[m] !== 1'b0) || (data_w[m] !== 1'b0)) viol++;
          if (!cs_prev[m]) begin
            if (abort[m]) begin
              abort[m] = 1'b0;
            end else if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: inst %0d got %06h, expected no frame", m, rx[m]);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              check("frame_inst", m, e.inst);
              check("frame_data", rx[m], e.frame);
              check("frame_bits", nbits[m], 24);
              check("cs_low_cycles", cslen[m], e.cs_len);
            end
            rx[m] = '0; nbits[m] = 0; cslen[m] = 0;
          end
        end
        cs_prev[m] = cs_w[m]; sclk_prev[m] = sclk_w[m]; data_prev[m] = data_w[m];
      end
    end
  end

  task automatic run(input int m, input logic [127:0] smp, input int restart,
                     output int busy_cyc, output int clips, output int ovr);
    int n;
    bit done;
    @(negedge clk);
    samp01 = smp[63:0];
    samp2  = smp;
    start[m] = 1'b1;
    busy_cyc = 0; clips = 0; ovr = 0; n = 0; done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start[m] = (n == restart);
      if (n == restart) begin
        samp01 = ~samp01;
        samp2  = ~samp2;
      end
      if (busy_w[m]) busy_cyc++; else done = 1'b1;
      if (clip_w[m]) clips++;
      if (ovr_w[m])  ovr++;
    end
    start[m] = 1'b0;
    check("busy_timeout", done, 1);
    repeat (3) begin
      @(negedge clk);
      if (busy_w[m]) busy_cyc++;
      if (clip_w[m]) clips++;
      if (ovr_w[m])  ovr++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int   b, c, o;

    vecs[0] = '{0, 32'h0000_0000, 32'h0000_0000, 24'h318140, 24'h328140, 0};
    vecs[1] = '{0, 32'h7FFF_0000, 32'hFFFD_0000, 24'h31FFFF, 24'h320000, 2};
    vecs[2] = '{1, 32'hFFFD_0000, 32'h0000_0000, 24'h31C140, 24'h328140, 0};
    vecs[3] = '{0, 32'h0001_FAFF, 32'hFFFD_FB00, 24'h31FFFF, 24'h320000, 0};
    vecs[4] = '{0, 32'h0001_FB00, 32'hFFFD_FAFF, 24'h31FFFF, 24'h320000, 2};
    vecs[5] = '{1, 32'h7FFF_0000, 32'h0001_FB00, 24'h314140, 24'h320000, 0};

    rst = 1'b1;
    samp01 = '0;
    samp2  = '0;
    for (int m = 0; m < 3; m++) begin
      start[m] = 1'b0; rx[m] = '0; nbits[m] = 0; cslen[m] = 0; abort[m] = 1'b0;
      cs_prev[m] = 1'b1; sclk_prev[m] = 1'b0; data_prev[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset_cs", cs_w[0], 1);
    check("reset_sclk", sclk_w[0], 0);
    check("reset_data", data_w[0], 0);
    check("reset_busy", busy_w[0], 0);
    check("reset_clip", clip_w[0], 0);
    check("reset_overrun", ovr_w[0], 0);
    check("reset_cs_ch4", cs_w[2], 1);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].inst, vecs[i].f0, 96);
      push_exp(vecs[i].inst, vecs[i].f1, 96);
      run(vecs[i].inst, {64'h0, vecs[i].s1, vecs[i].s0}, 0, b, c, o);
      check("vec_busy_cycles", b, 200);
      check("vec_clip_pulses", c, vecs[i].clips);
      check("vec_overrun", o, 0);
      check("vec_frames_pending", exp_q.size(), 0);
    end

    // Restart mid-transfer: dropped, samples changed at the same time are ignored.
    push_exp(0, 24'h318140, 96);
    push_exp(0, 24'h328140, 96);
    run(0, 128'h0, 50, b, c, o);
    check("ovr50_busy_cycles", b, 200);
    check("ovr50_overrun_pulses", o, 1);
    check("ovr50_frames_pending", exp_q.size(), 0);

    // Start on the last GAP cycle is still an overrun.
    push_exp(0, 24'h318140, 96);
    push_exp(0, 24'h328140, 96);
    run(0, 128'h0, 200, b, c, o);
    check("ovr200_busy_cycles", b, 200);
    check("ovr200_overrun_pulses", o, 1);
    check("ovr200_frames_pending", exp_q.size(), 0);

    // Reset in the middle of frame 0.
    abort[0] = 1'b1;
    @(negedge clk);
    samp01 = '0;
    start[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (n == 40) begin
        check("midframe_cs_low", cs_w[0], 0);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    check("rst_mid_cs", cs_w[0], 1);
    check("rst_mid_sclk", sclk_w[0], 0);
    check("rst_mid_data", data_w[0], 0);
    check("rst_mid_busy", busy_w[0], 0);
    rst = 1'b0;
    push_exp(0, 24'h318140, 96);
    push_exp(0, 24'h328140, 96);
    run(0, 128'h0, 0, b, c, o);
    check("post_rst_busy_cycles", b, 200);
    check("post_rst_frames_pending", exp_q.size(), 0);

    // Four channels, fast SCLK, single-cycle gap.
    push_exp(2, 24'h318140, 48);
    push_exp(2, 24'h32C140, 48);
    push_exp(2, 24'h33FFFF, 48);
    push_exp(2, 24'h340000, 48);
    run(2, {32'hFFFD_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0000_0000}, 0, b, c, o);
    check("ch4_busy_cycles", b, 204);
    check("ch4_clip_pulses", c, 2);
    check("ch4_overrun", o, 0);
    check("ch4_frames_pending", exp_q.size(), 0);

    repeat (20) @(negedge clk);
    check("idle_and_data_rule_violations", viol, 0);
    check("final_frames_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
